// File: rtl/sonar_ranger_if.sv
// Sonar ranger sensor/consumer bundle: echo in, trigger and measurement results out.
// Latency: n/a (wiring only).
// Backpressure: none; dist_valid is a one-cycle strobe with no ready.
//
// Signals:
//   echo       raw sensor echo (asynchronous to the ranger clock)
//   trig       sensor trigger pulse
//   dist_cm    last measured distance, held between updates
//   dist_valid one-cycle strobe when dist_cm/near/timeout update
//   near       obstacle closer than the stop threshold
//   timeout    last measurement saw no complete echo
// Modports: master = ranger side, slave = sensor/consumer side.
interface sonar_ranger_if #(
    parameter int DIST_W = 9
);
    logic              echo;
    logic              trig;
    logic [DIST_W-1:0] dist_cm;
    logic              dist_valid;
    logic              near;
    logic              timeout;

    modport master (
        input  echo,
        output trig,
        output dist_cm,
        output dist_valid,
        output near,
        output timeout
    );

    modport slave (
        output echo,
        input  trig,
        input  dist_cm,
        input  dist_valid,
        input  near,
        input  timeout
    );
endinterface

// File: rtl/sonar_ranger.sv
// Ultrasonic range front end: periodic trigger, echo pulse timing in us ticks, conversion to cm.
// Latency: dist_valid 3 cycles after the raw echo falls (2 sync FFs + edge detect), +-1 us quantisation.
// Backpressure: none; results are published with a one-cycle dist_valid strobe and held until the next one.
//
// Ports:
//   clk0  system clock, all logic on posedge
//   rst   synchronous active-high reset; aborts any measurement, trig low on the next edge
//   bus   sonar_ranger_if.master: echo in; trig, dist_cm, dist_valid, near, timeout out
// Build option: define NEAR_HYST_EN to give the near flag a release hysteresis of HYST_CM.
module sonar_ranger #(
    parameter int TICKS_PER_US = 50,
    parameter int TRIG_US      = 10,
    parameter int PERIOD_US    = 60000,
    parameter int TIMEOUT_US   = 25000,
    parameter int US_PER_CM    = 58,
    parameter int DIST_W       = 9,
    parameter int STOP_CM      = 20,
    parameter int HYST_CM      = 5
) (
    input  logic clk0,
    input  logic rst,
    sonar_ranger_if.master bus
);
    localparam int PRE_W = $clog2(TICKS_PER_US + 1);
    localparam int PER_W = $clog2(PERIOD_US + 1);
    localparam int PH_W  = $clog2(((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US) + 1);
    localparam int SUB_W = $clog2(US_PER_CM + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICKS_PER_US - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_US - 1);
    localparam logic [PH_W-1:0]   TRIG_LAST = PH_W'(TRIG_US - 1);
    localparam logic [PH_W-1:0]   TO_LAST   = PH_W'(TIMEOUT_US - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(US_PER_CM - 1);
    localparam logic [DIST_W-1:0] CM_MAX    = '1;
    localparam logic [DIST_W-1:0] STOP_V    = DIST_W'(STOP_CM);
`ifdef NEAR_HYST_EN
    localparam logic [DIST_W-1:0] REL_V     = DIST_W'(STOP_CM + HYST_CM);
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t state, state_n;

    // Echo synchroniser plus one extra stage for edge detection.
    logic echo_s1, echo_s2, echo_d;
    logic echo_rise, echo_fall;

    logic [PRE_W-1:0]  pre_cnt;
    logic [PER_W-1:0]  per_cnt;
    logic [PH_W-1:0]   ph_cnt;
    logic [SUB_W-1:0]  sub_cnt;
    logic [DIST_W-1:0] cm_cnt;
    logic              first_pass;
    logic              us_tick;
    logic              trig_enter;
    logic              done_enter;
    logic              done_to;
    logic              near_n;

    logic [DIST_W-1:0] dist_q;
    logic              near_q;
    logic              timeout_q;
    logic              trig_o;
    logic              valid_o;

    always_ff @(posedge clk0) begin
        if (rst) begin
            echo_s1 <= 1'b0;
            echo_s2 <= 1'b0;
            echo_d  <= 1'b0;
        end else begin
            echo_s1 <= bus.echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
        end
    end

    assign echo_rise  = echo_s2 & ~echo_d;
    assign echo_fall  = ~echo_s2 & echo_d;
    assign us_tick    = (pre_cnt == PRE_LAST);
    assign trig_enter = (state_n == TRIG) && (state != TRIG);
    assign done_enter = (state_n == DONE) && (state != DONE);

    // Prescaler restarts with every trigger so the trigger pulse and the
    // start-to-start period are exact multiples of the microsecond.
    always_ff @(posedge clk0) begin
        if (rst || trig_enter || us_tick) pre_cnt <= '0;
        else                              pre_cnt <= pre_cnt + 1'b1;
    end

    always_ff @(posedge clk0) begin
        if (rst || trig_enter)                 per_cnt <= '0;
        else if (us_tick && per_cnt != PER_LAST) per_cnt <= per_cnt + 1'b1;
    end

    always_ff @(posedge clk0) begin
        if (rst)             first_pass <= 1'b1;
        else if (trig_enter) first_pass <= 1'b0;
    end

    // Per-state microsecond counter, restarted on every state change.
    always_ff @(posedge clk0) begin
        if (rst || state_n != state)
            ph_cnt <= '0;
        else if (us_tick && (state == TRIG || state == WAIT_RISE || state == MEASURE))
            ph_cnt <= ph_cnt + 1'b1;
    end

    // Echo width in cm: sub counts microseconds within one cm, cm saturates.
    always_ff @(posedge clk0) begin
        if (rst) begin
            sub_cnt <= '0;
            cm_cnt  <= '0;
        end else if (state == WAIT_RISE && echo_rise) begin
            sub_cnt <= '0;
            cm_cnt  <= '0;
        end else if (state == MEASURE && us_tick) begin
            if (sub_cnt == SUB_LAST) begin
                sub_cnt <= '0;
                if (cm_cnt != CM_MAX) cm_cnt <= cm_cnt + 1'b1;
            end else begin
                sub_cnt <= sub_cnt + 1'b1;
            end
        end
    end

    // FSM: state register.
    always_ff @(posedge clk0) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // FSM: next state. An echo already high when WAIT_RISE is entered gives
    // no rising edge, so it is ignored until it drops and rises again.
    always_comb begin
        state_n = state;
        done_to = 1'b0;
        case (state)
            IDLE: begin
                if (first_pass || (us_tick && per_cnt == PER_LAST)) state_n = TRIG;
            end
            TRIG: begin
                if (us_tick && ph_cnt == TRIG_LAST) state_n = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    state_n = MEASURE;
                end else if (us_tick && ph_cnt == TO_LAST) begin
                    state_n = DONE;
                    done_to = 1'b1;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    state_n = DONE;
                end else if (us_tick && ph_cnt == TO_LAST) begin
                    state_n = DONE;
                    done_to = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        trig_o  = 1'b0;
        valid_o = 1'b0;
        case (state)
            TRIG:    trig_o  = 1'b1;
            DONE:    valid_o = 1'b1;
            default: ;
        endcase
    end

`ifdef NEAR_HYST_EN
    always_comb begin
        near_n = near_q;
        if (cm_cnt < STOP_V)      near_n = 1'b1;
        else if (cm_cnt >= REL_V) near_n = 1'b0;
    end
`else
    always_comb begin
        near_n = (cm_cnt < STOP_V);
    end
`endif

    // Results are loaded on the edge into DONE so they are visible together
    // with the dist_valid strobe.
    always_ff @(posedge clk0) begin
        if (rst) begin
            dist_q    <= CM_MAX;
            near_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else if (done_enter) begin
            if (done_to) begin
                dist_q    <= CM_MAX;
                near_q    <= 1'b0;
                timeout_q <= 1'b1;
            end else begin
                dist_q    <= cm_cnt;
                near_q    <= near_n;
                timeout_q <= 1'b0;
            end
        end
    end

    assign bus.trig       = trig_o;
    assign bus.dist_valid = valid_o;
    assign bus.dist_cm    = dist_q;
    assign bus.near       = near_q;
    assign bus.timeout    = timeout_q;
endmodule
